// File: rtl/model_vector_float_divider_multilane.sv
// Multilane IEEE-style float vector divider: batches of up to LANES elements are
// captured, divided in parallel scalar dividers, then streamed out in input order.

module model_scalar_float_divider #(
  parameter int DATA_SIZE = 64
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic [DATA_SIZE-1:0] DATA_A_IN,
  input  logic [DATA_SIZE-1:0] DATA_B_IN,
  output logic                 READY,
  output logic [DATA_SIZE-1:0] DATA_OUT
);
  // state  | meaning
  // S_IDLE | waiting for START; zero/inf/NaN operands resolved immediately
  // S_DIV  | restoring division, one quotient bit per cycle
  // S_NORM | normalise, round to nearest even, pack result
  localparam int EW = (DATA_SIZE >= 64) ? 11 : (DATA_SIZE >= 32) ? 8 : 5;
  localparam int FW = DATA_SIZE - 1 - EW;
  localparam int QW = FW + 3;
  localparam int CW = $clog2(QW + 1);
  localparam logic signed [EW+1:0] EXP_BIAS = (EW+2)'((1 << (EW - 1)) - 1);
  localparam logic signed [EW+1:0] EXP_MAX  = (EW+2)'((1 << EW) - 1);
  localparam logic signed [EW+1:0] EXP_ONE  = (EW+2)'(1);
  localparam logic [DATA_SIZE-1:0] QNAN = {1'b0, {EW{1'b1}}, 1'b1, {(FW-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_NORM} state_t;
  state_t state_q, state_d;

  logic                 sa, sb, sq;
  logic [EW-1:0]        ea, eb;
  logic [FW-1:0]        fa, fb;
  logic                 a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, special;
  logic [DATA_SIZE-1:0] special_val;

  logic                 sign_q;
  logic signed [EW+1:0] exp_q;
  logic [FW+1:0]        rem_q;
  logic [FW:0]          div_q;
  logic [QW-1:0]        quo_q;
  logic [CW-1:0]        cnt_q;

  logic                 rem_ge;
  logic [FW+1:0]        rem_sub;
  logic [FW:0]          man;
  logic [FW+1:0]        man_r;
  logic [FW-1:0]        frac_n;
  logic signed [EW+1:0] exp_n;
  logic                 guard, sticky;
  logic [DATA_SIZE-1:0] packed_val;

  assign {sa, ea, fa} = DATA_A_IN;
  assign {sb, eb, fb} = DATA_B_IN;
  assign sq     = sa ^ sb;
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (&ea) && (fa == '0);
  assign b_inf  = (&eb) && (fb == '0);
  assign a_nan  = (&ea) && (|fa);
  assign b_nan  = (&eb) && (|fb);
  assign special = a_zero | b_zero | a_inf | b_inf | a_nan | b_nan;

  // Subnormal operands are treated as zero.
  always_comb begin
    special_val = {sq, {(DATA_SIZE-1){1'b0}}};
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf))
      special_val = QNAN;
    else if (a_inf || b_zero)
      special_val = {sq, {EW{1'b1}}, {FW{1'b0}}};
  end

  assign rem_ge  = (rem_q >= {1'b0, div_q});
  assign rem_sub = rem_ge ? (rem_q - {1'b0, div_q}) : rem_q;

  always_comb begin
    man    = quo_q[QW-2:1];
    guard  = quo_q[0];
    sticky = |rem_q;
    exp_n  = exp_q - EXP_ONE;
    if (quo_q[QW-1]) begin
      man    = quo_q[QW-1:2];
      guard  = quo_q[1];
      sticky = quo_q[0] | (|rem_q);
      exp_n  = exp_q;
    end
    man_r  = {1'b0, man} + {{(FW+1){1'b0}}, guard & (sticky | man[0])};
    frac_n = man_r[FW-1:0];
    if (man_r[FW+1]) begin
      exp_n  = exp_n + EXP_ONE;
      frac_n = man_r[FW:1];
    end
    if (exp_n >= EXP_MAX)
      packed_val = {sign_q, {EW{1'b1}}, {FW{1'b0}}};
    else if (exp_n[EW+1] || exp_n == '0)
      packed_val = {sign_q, {(DATA_SIZE-1){1'b0}}};
    else
      packed_val = {sign_q, exp_n[EW-1:0], frac_n};
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (START && !special) state_d = S_DIV;
      S_DIV:  if (cnt_q == CW'(1)) state_d = S_NORM;
      S_NORM: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      READY    <= 1'b0;
      DATA_OUT <= '0;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      rem_q    <= '0;
      div_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
    end else begin
      READY <= 1'b0;
      case (state_q)
        S_IDLE: if (START) begin
          if (special) begin
            DATA_OUT <= special_val;
            READY    <= 1'b1;
          end else begin
            sign_q <= sq;
            exp_q  <= $signed({2'b00, ea}) - $signed({2'b00, eb}) + EXP_BIAS;
            rem_q  <= {1'b0, 1'b1, fa};
            div_q  <= {1'b1, fb};
            quo_q  <= '0;
            cnt_q  <= CW'(QW);
          end
        end
        S_DIV: begin
          quo_q <= {quo_q[QW-2:0], rem_ge};
          rem_q <= {rem_sub[FW:0], 1'b0};
          cnt_q <= cnt_q - CW'(1);
        end
        S_NORM: begin
          DATA_OUT <= packed_val;
          READY    <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

module model_vector_float_divider_multilane #(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 64,
  parameter int LANES        = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    START,
  output logic                    READY,
  output logic                    BUSY,
  input  logic                    DATA_A_IN_ENABLE,
  input  logic                    DATA_B_IN_ENABLE,
  input  logic [CONTROL_SIZE-1:0] SIZE_IN,
  input  logic [DATA_SIZE-1:0]    DATA_A_IN,
  input  logic [DATA_SIZE-1:0]    DATA_B_IN,
  output logic [DATA_SIZE-1:0]    DATA_OUT,
  output logic                    DATA_OUT_ENABLE,
  output logic                    DIV_ZERO
);
  // state   | meaning
  // IDLE    | waiting for START
  // INPUT   | filling A/B lane slots for the current batch
  // COMPUTE | active lanes dividing; results collected per lane
  // OUTPUT  | streaming batch results, lane 0 first
  localparam int LW = $clog2(LANES + 1);

  typedef enum logic [1:0] {IDLE, INPUT, COMPUTE, OUTPUT} state_t;
  state_t state_q, state_d;

  logic [CONTROL_SIZE-1:0] size_q, index_q, remain, batch_ext;
  logic [LW-1:0]           fill_a_q, fill_b_q, out_sel_q, batch;
  logic [LANES-1:0]        done_q, lane_start_q, lane_ready, active;
  logic [DATA_SIZE-1:0]    a_slot_q [LANES];
  logic [DATA_SIZE-1:0]    b_slot_q [LANES];
  logic [DATA_SIZE-1:0]    res_q    [LANES];
  logic [DATA_SIZE-1:0]    lane_out [LANES];
  logic [DATA_SIZE-1:0]    hold_q, cur_res;
  logic                    accept_a, accept_b, fills_full, all_done, last_out, vec_end;

  assign remain    = size_q - index_q;
  assign batch     = (remain < CONTROL_SIZE'(LANES)) ? remain[LW-1:0] : LW'(LANES);
  assign batch_ext = CONTROL_SIZE'(batch);

  assign accept_a   = (state_q == INPUT) && DATA_A_IN_ENABLE && (fill_a_q != batch);
  assign accept_b   = (state_q == INPUT) && DATA_B_IN_ENABLE && (fill_b_q != batch);
  assign fills_full = (fill_a_q == batch) && (fill_b_q == batch);
  assign all_done   = ((done_q & active) == active);
  assign last_out   = (out_sel_q == batch - LW'(1));
  assign vec_end    = ((index_q + batch_ext) == size_q);

  always_comb begin
    active  = '0;
    cur_res = '0;
    for (int i = 0; i < LANES; i++) begin
      active[i] = (LW'(i) < batch);
      if (out_sel_q == LW'(i)) cur_res = res_q[i];
    end
  end

  assign BUSY            = (state_q != IDLE);
  assign DATA_OUT_ENABLE = (state_q == OUTPUT);
  assign DATA_OUT        = DATA_OUT_ENABLE ? cur_res : hold_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (START && SIZE_IN != '0) state_d = INPUT;
      INPUT:   if (fills_full) state_d = COMPUTE;
      COMPUTE: if (all_done) state_d = OUTPUT;
      OUTPUT:  if (last_out) state_d = vec_end ? IDLE : INPUT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      READY        <= 1'b0;
      DIV_ZERO     <= 1'b0;
      size_q       <= '0;
      index_q      <= '0;
      fill_a_q     <= '0;
      fill_b_q     <= '0;
      out_sel_q    <= '0;
      done_q       <= '0;
      lane_start_q <= '0;
      hold_q       <= '0;
      for (int i = 0; i < LANES; i++) begin
        a_slot_q[i] <= '0;
        b_slot_q[i] <= '0;
        res_q[i]    <= '0;
      end
    end else begin
      READY        <= 1'b0;
      lane_start_q <= '0;
      case (state_q)
        IDLE: if (START) begin
          size_q    <= SIZE_IN;
          index_q   <= '0;
          DIV_ZERO  <= 1'b0;
          fill_a_q  <= '0;
          fill_b_q  <= '0;
          out_sel_q <= '0;
          done_q    <= '0;
          if (SIZE_IN == '0) READY <= 1'b1;
        end
        INPUT: begin
          if (accept_a) fill_a_q <= fill_a_q + LW'(1);
          if (accept_b) fill_b_q <= fill_b_q + LW'(1);
          if (accept_b && DATA_B_IN[DATA_SIZE-2:0] == '0) DIV_ZERO <= 1'b1;
          for (int i = 0; i < LANES; i++) begin
            if (accept_a && fill_a_q == LW'(i)) a_slot_q[i] <= DATA_A_IN;
            if (accept_b && fill_b_q == LW'(i)) b_slot_q[i] <= DATA_B_IN;
          end
          if (fills_full) begin
            lane_start_q <= active;
            done_q       <= '0;
          end
        end
        COMPUTE: begin
          for (int i = 0; i < LANES; i++) begin
            if (lane_ready[i]) begin
              done_q[i] <= 1'b1;
              res_q[i]  <= lane_out[i];
            end
          end
        end
        OUTPUT: begin
          hold_q    <= cur_res;
          out_sel_q <= out_sel_q + LW'(1);
          if (last_out) begin
            out_sel_q <= '0;
            fill_a_q  <= '0;
            fill_b_q  <= '0;
            done_q    <= '0;
            index_q   <= index_q + batch_ext;
            if (vec_end) READY <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    model_scalar_float_divider #(.DATA_SIZE(DATA_SIZE)) u_div (
      .CLK      (CLK),
      .RST      (RST),
      .START    (lane_start_q[g]),
      .DATA_A_IN(a_slot_q[g]),
      .DATA_B_IN(b_slot_q[g]),
      .READY    (lane_ready[g]),
      .DATA_OUT (lane_out[g])
    );
  end
endmodule

// File: tb/tb_model_vector_float_divider_multilane.sv
// Directed bench for the multilane vector divider; expected quotients come from
// real-valued division in the bench, with literal pins on key results.

module tb_model_vector_float_divider_multilane;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        START = 1'b0;
  logic        READY, BUSY, DATA_OUT_ENABLE, DIV_ZERO;
  logic        DATA_A_IN_ENABLE = 1'b0;
  logic        DATA_B_IN_ENABLE = 1'b0;
  logic [63:0] SIZE_IN = '0;
  logic [63:0] DATA_A_IN = '0;
  logic [63:0] DATA_B_IN = '0;
  logic [63:0] DATA_OUT;

  model_vector_float_divider_multilane #(.DATA_SIZE(64), .CONTROL_SIZE(64), .LANES(4)) dut (
    .CLK(CLK), .RST(RST), .START(START), .READY(READY), .BUSY(BUSY),
    .DATA_A_IN_ENABLE(DATA_A_IN_ENABLE), .DATA_B_IN_ENABLE(DATA_B_IN_ENABLE),
    .SIZE_IN(SIZE_IN), .DATA_A_IN(DATA_A_IN), .DATA_B_IN(DATA_B_IN),
    .DATA_OUT(DATA_OUT), .DATA_OUT_ENABLE(DATA_OUT_ENABLE), .DIV_ZERO(DIV_ZERO)
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;
  int out_cnt = 0;
  int ready_cnt = 0;
  logic [63:0] exp_q[$];
  logic [63:0] got_q[$];
  logic [63:0] av[$];
  logic [63:0] bv[$];

  function automatic logic [63:0] div_model(input logic [63:0] a, input logic [63:0] b);
    if (b[62:0] == 63'd0) return {a[63] ^ b[63], 11'h7ff, 52'd0};
    return $realtobits($bitstoreal(a) / $bitstoreal(b));
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (!RST) begin
      if (DATA_OUT_ENABLE) begin
        got_q.push_back(DATA_OUT);
        out_cnt++;
        check1("busy_during_output", BUSY, 1'b1);
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_output: got %h expected none", DATA_OUT);
        end else begin
          check("data_out", DATA_OUT, exp_q.pop_front());
        end
      end
      if (READY) ready_cnt++;
    end
  end

  task automatic start_vec(input int n);
    @(posedge CLK); #1;
    START = 1'b1;
    SIZE_IN = 64'(n);
    @(posedge CLK); #1;
    START = 1'b0;
  endtask

  task automatic feed_batch(input int base, input int n, input int lag_a, input int lag_b);
    int span;
    span = n + ((lag_a > lag_b) ? lag_a : lag_b);
    @(posedge CLK); #1;
    for (int c = 0; c < span; c++) begin
      DATA_A_IN_ENABLE = (c >= lag_a) && (c - lag_a < n);
      DATA_B_IN_ENABLE = (c >= lag_b) && (c - lag_b < n);
      if (DATA_A_IN_ENABLE) DATA_A_IN = av[base + c - lag_a];
      if (DATA_B_IN_ENABLE) DATA_B_IN = bv[base + c - lag_b];
      @(posedge CLK); #1;
    end
    DATA_A_IN_ENABLE = 1'b0;
    DATA_B_IN_ENABLE = 1'b0;
    for (int k = 0; k < n; k++) exp_q.push_back(div_model(av[base + k], bv[base + k]));
  endtask

  task automatic wait_outputs(input int target, input string name);
    for (int k = 0; k < 400 && out_cnt < target; k++) @(negedge CLK);
    check(name, 64'(out_cnt), 64'(target));
  endtask

  task automatic wait_ready(input int target, input string name);
    for (int k = 0; k < 400 && ready_cnt < target; k++) @(negedge CLK);
    check(name, 64'(ready_cnt), 64'(target));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int o0, r0;

    // model pins
    check("pin_6_div_2", div_model($realtobits(6.0), $realtobits(2.0)), 64'h4008000000000000);
    check("pin_1_div_3", div_model($realtobits(1.0), $realtobits(3.0)), 64'h3FD5555555555555);
    check("pin_1_div_7", div_model($realtobits(1.0), $realtobits(7.0)), 64'h3FC2492492492492);
    check("pin_m3_div_m0", div_model($realtobits(-3.0), 64'h8000000000000000), 64'h7FF0000000000000);

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check1("rst_ready", READY, 1'b0);
    check1("rst_busy", BUSY, 1'b0);
    check1("rst_out_en", DATA_OUT_ENABLE, 1'b0);
    check("rst_data_out", DATA_OUT, 64'd0);
    check1("rst_div_zero", DIV_ZERO, 1'b0);
    @(posedge CLK); #1;
    RST = 1'b0;

    // single full batch
    av = '{$realtobits(6.0), $realtobits(1.0), $realtobits(9.0), $realtobits(-8.0)};
    bv = '{$realtobits(2.0), $realtobits(4.0), $realtobits(3.0), $realtobits(2.0)};
    got_q.delete();
    start_vec(4);
    feed_batch(0, 4, 0, 0);
    wait_outputs(4, "t1_out_count");
    wait_ready(1, "t1_ready");
    check1("t1_div_zero", DIV_ZERO, 1'b0);
    check("t1_q0", got_q[0], 64'h4008000000000000);
    check("t1_q1", got_q[1], 64'h3FD0000000000000);
    check("t1_q2", got_q[2], 64'h4008000000000000);
    check("t1_q3", got_q[3], 64'hC010000000000000);

    // two batches, B lagging A by three cycles
    av = '{$realtobits(1.0), $realtobits(10.0), $realtobits(-7.0), $realtobits(100.0),
           $realtobits(1.0), $realtobits(5.0)};
    bv = '{$realtobits(3.0), $realtobits(4.0), $realtobits(2.0), $realtobits(-8.0),
           $realtobits(7.0), $realtobits(0.5)};
    got_q.delete();
    o0 = out_cnt; r0 = ready_cnt;
    start_vec(6);
    feed_batch(0, 4, 0, 3);
    wait_outputs(o0 + 4, "t2_batch1_count");
    check1("t2_no_ready_mid", (ready_cnt == r0), 1'b1);
    feed_batch(4, 2, 0, 3);
    wait_outputs(o0 + 6, "t2_batch2_count");
    wait_ready(r0 + 1, "t2_ready");
    check("t2_q3", got_q[3], 64'hC029000000000000);
    check("t2_q5", got_q[5], 64'h4024000000000000);
    repeat (20) @(negedge CLK);
    check("t2_final_count", 64'(out_cnt), 64'(o0 + 6));
    check("t2_single_ready", 64'(ready_cnt), 64'(r0 + 1));

    // zero-length vector
    o0 = out_cnt;
    @(posedge CLK); #1;
    START = 1'b1;
    SIZE_IN = 64'd0;
    @(negedge CLK);
    check1("t3_busy_at_start", BUSY, 1'b0);
    @(posedge CLK); #1;
    START = 1'b0;
    @(negedge CLK);
    check1("t3_ready", READY, 1'b1);
    check1("t3_busy", BUSY, 1'b0);
    check1("t3_out_en", DATA_OUT_ENABLE, 1'b0);
    @(negedge CLK);
    check1("t3_ready_pulse_end", READY, 1'b0);
    check("t3_no_outputs", 64'(out_cnt), 64'(o0));

    // zero divisors, B arrives before A
    av = '{$realtobits(1.0), $realtobits(-3.0)};
    bv = '{64'h0000000000000000, 64'h8000000000000000};
    o0 = out_cnt; r0 = ready_cnt;
    start_vec(2);
    @(posedge CLK); #1;
    check1("t4_div_zero_before", DIV_ZERO, 1'b0);
    DATA_B_IN_ENABLE = 1'b1; DATA_B_IN = bv[0];
    @(posedge CLK); #1;
    check1("t4_div_zero_set", DIV_ZERO, 1'b1);
    DATA_A_IN_ENABLE = 1'b1; DATA_A_IN = av[0];
    DATA_B_IN = bv[1];
    @(posedge CLK); #1;
    DATA_B_IN_ENABLE = 1'b0;
    DATA_A_IN = av[1];
    @(posedge CLK); #1;
    DATA_A_IN_ENABLE = 1'b0;
    exp_q.push_back(div_model(av[0], bv[0]));
    exp_q.push_back(div_model(av[1], bv[1]));
    wait_outputs(o0 + 2, "t4_out_count");
    wait_ready(r0 + 1, "t4_ready");
    check1("t4_div_zero_at_ready", DIV_ZERO, 1'b1);

    // START and enables during COMPUTE are ignored
    av = '{$realtobits(9.0), $realtobits(-1.0), $realtobits(2.0)};
    bv = '{$realtobits(3.0), $realtobits(8.0), $realtobits(-0.5)};
    o0 = out_cnt; r0 = ready_cnt;
    start_vec(3);
    check1("t5_div_zero_cleared", DIV_ZERO, 1'b0);
    feed_batch(0, 3, 0, 0);
    @(posedge CLK); #1;
    START = 1'b1; SIZE_IN = 64'd9;
    DATA_A_IN_ENABLE = 1'b1; DATA_A_IN = $realtobits(4.0);
    DATA_B_IN_ENABLE = 1'b1; DATA_B_IN = 64'd0;
    repeat (4) @(posedge CLK);
    #1;
    START = 1'b0; DATA_A_IN_ENABLE = 1'b0; DATA_B_IN_ENABLE = 1'b0;
    wait_outputs(o0 + 3, "t5_out_count");
    wait_ready(r0 + 1, "t5_ready");
    check1("t5_div_zero", DIV_ZERO, 1'b0);
    repeat (100) @(negedge CLK);
    check("t5_final_count", 64'(out_cnt), 64'(o0 + 3));
    check1("t5_idle", BUSY, 1'b0);

    // reset during COMPUTE abandons the vector
    av = '{$realtobits(1.0), $realtobits(2.0), $realtobits(3.0), $realtobits(4.0)};
    bv = '{$realtobits(2.0), 64'd0, $realtobits(1.0), $realtobits(1.0)};
    start_vec(5);
    feed_batch(0, 4, 0, 0);
    repeat (10) @(posedge CLK);
    #1;
    check1("t6_busy_before_rst", BUSY, 1'b1);
    check1("t6_div_zero_before_rst", DIV_ZERO, 1'b1);
    RST = 1'b1;
    #1;
    check1("t6_rst_busy", BUSY, 1'b0);
    check1("t6_rst_ready", READY, 1'b0);
    check1("t6_rst_out_en", DATA_OUT_ENABLE, 1'b0);
    check("t6_rst_data_out", DATA_OUT, 64'd0);
    check1("t6_rst_div_zero", DIV_ZERO, 1'b0);
    exp_q.delete();
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    o0 = out_cnt; r0 = ready_cnt;
    repeat (120) @(negedge CLK);
    check("t6_no_outputs", 64'(out_cnt), 64'(o0));
    check("t6_no_ready", 64'(ready_cnt), 64'(r0));
    av = '{$realtobits(1.0)};
    bv = '{$realtobits(2.0)};
    got_q.delete();
    start_vec(1);
    feed_batch(0, 1, 0, 0);
    wait_outputs(o0 + 1, "t6_out_count");
    wait_ready(r0 + 1, "t6_ready");
    check("t6_q0", got_q[0], 64'h3FE0000000000000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/model_vector_float_divider_multilane.md
MODEL_VECTOR_FLOAT_DIVIDER_MULTILANE -- requirements
Module: model_vector_float_divider_multilane

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 64, element width in bits (IEEE-style: sign at MSB).
REQ-002 SHALL have parameter CONTROL_SIZE, default 64, index/counter width.
REQ-003 SHALL have parameter LANES, default 4, number of parallel model_scalar_float_divider instances; legal range 1..16.
REQ-004 SHALL have port CLK  input  1  clock, all logic on rising edge.
REQ-005 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port START  input  1  begin a vector operation; sampled only in IDLE.
REQ-007 SHALL have port READY  output  1  one-cycle pulse when the whole vector has been output.
REQ-008 SHALL have port BUSY  output  1  high in every state except IDLE.
REQ-009 SHALL have port DATA_A_IN_ENABLE  input  1  DATA_A_IN valid this cycle.
REQ-010 SHALL have port DATA_B_IN_ENABLE  input  1  DATA_B_IN valid this cycle.
REQ-011 SHALL have port SIZE_IN  input  CONTROL_SIZE  vector length; latched on accepted START.
REQ-012 SHALL have port DATA_A_IN  input  DATA_SIZE  dividend element.
REQ-013 SHALL have port DATA_B_IN  input  DATA_SIZE  divisor element.
REQ-014 SHALL have port DATA_OUT  output  DATA_SIZE  quotient element.
REQ-015 SHALL have port DATA_OUT_ENABLE  output  1  DATA_OUT valid this cycle.
REQ-016 SHALL have port DIV_ZERO  output  1  sticky: some accepted divisor had bits [DATA_SIZE-2:0] all zero.

Function
REQ-017 SHALL implement FSM states IDLE, INPUT, COMPUTE, OUTPUT.
REQ-018 IDLE: on START=1 SHALL latch SIZE_IN, clear element index to 0, clear DIV_ZERO, go INPUT; if SIZE_IN=0 SHALL instead pulse READY next cycle and stay IDLE.
REQ-019 START outside IDLE SHALL be ignored.
REQ-020 Batch size SHALL be min(LANES, size - index).
REQ-021 INPUT: A and B elements SHALL be captured independently into lane slots via separate fill counters; A and B of one element may arrive in different cycles, in either order.
REQ-022 An enable SHALL be ignored when its fill counter equals batch size, and in any state other than INPUT.
REQ-023 Each accepted B with zero magnitude SHALL set DIV_ZERO; the element is still divided.
REQ-024 When both fill counters equal batch size, FSM SHALL go COMPUTE and assert START of lanes 0..batch-1 for exactly one cycle; unused lanes SHALL not be started.
REQ-025 COMPUTE: each lane's READY pulse SHALL set a per-lane done bit and register that lane's DATA_OUT; when all active lanes are done, FSM SHALL go OUTPUT.
REQ-026 OUTPUT: SHALL emit one result per cycle, lane 0 first, DATA_OUT_ENABLE=1 each such cycle, element order equal to input order.
REQ-027 After last result of a batch: index += batch; if index = size SHALL pulse READY in the following cycle and return IDLE, else clear fill counters/done bits and return INPUT.
REQ-028 DATA_OUT SHALL hold its last value when DATA_OUT_ENABLE=0; DATA_OUT_ENABLE SHALL be 0 outside OUTPUT.
REQ-029 Quotient SHALL be exactly the scalar divider's result; no rounding or modification here.
REQ-030 Index arithmetic SHALL be CONTROL_SIZE wide, no wrap for SIZE_IN < 2^CONTROL_SIZE - LANES.

Reset
REQ-031 RST=1 SHALL asynchronously force IDLE, READY=0, BUSY=0, DATA_OUT_ENABLE=0, DATA_OUT=0, DIV_ZERO=0, all counters, done bits and lane starts 0; RST SHALL propagate to all lanes.
REQ-032 RST mid-operation SHALL abandon the vector; no output pulses after release until a new START.

Verification
REQ-033 LANES=4, SIZE=4, A={6.0,1.0,9.0,-8.0}, B={2.0,4.0,3.0,2.0} -> four outputs {3.0,0.25,3.0,-4.0} in order, then READY pulse, DIV_ZERO=0.
REQ-034 LANES=4, SIZE=6, B enables lag A by 3 cycles -> batches of 4 then 2, six correct outputs in order, one READY pulse, lanes 2-3 idle in batch 2.
REQ-035 SIZE=0 START -> READY pulse next cycle, no DATA_OUT_ENABLE, BUSY stays 0.
REQ-036 SIZE=2, B={0.0,-0.0} -> DIV_ZERO=1 after first B accepted, stays 1 through READY, clears on next START.
REQ-037 START and extra enables during COMPUTE -> ignored; output count equals SIZE.
REQ-038 RST asserted in COMPUTE -> all outputs 0 immediately; new START with SIZE=1, A=1.0, B=2.0 -> single output 0.5 and READY.
